seg7_scan_ctrl: RTL and testbench

//  Time-multiplexes one shared active-low 7-segment bus (seg) across DIGITS common-anode digits (en).

---
 rtl/seg7_pkg.sv | 35 +++
 rtl/seg7_hex_decode.sv | 12 +
 rtl/seg7_scan_ctrl.sv | 97 +++++++++
 tb/tb_seg7_scan_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared 7-segment constants, phase type and hex glyph table
package seg7_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } phase_t;

    // Active-low {g,f,e,d,c,b,a} glyphs for 0..9, A, b, C, d, E, F
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// rtl/seg7_hex_decode.sv - combinational nibble+dp to active-low segment byte
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib_i,
    input  logic       dp_i,
    output logic [7:0] seg_o
);

    assign seg_o = {~dp_i, hex_to_seg(nib_i)};

endmodule

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - multiplexed 7-segment scanner with blanking dead time and digit register file
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int DIGITS    = 8,
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [2:0]        wr_addr,
    input  logic [3:0]        wr_data,
    input  logic              wr_dp,
    input  logic [DIGITS-1:0] dig_on,
    output logic [7:0]        seg,
    output logic [DIGITS-1:0] en
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(DIGITS);
    localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    logic [CW-1:0]          slot_cnt_q, slot_cnt_d;
    logic [IW-1:0]          digit_idx_q, digit_idx_d;
    phase_t                 phase_q, phase_d;
    logic [DIGITS-1:0][3:0] nib_q;
    logic [DIGITS-1:0]      dp_q;
    logic [7:0]             seg_q, seg_d;
    logic [DIGITS-1:0]      en_q, en_d;
    logic [7:0]             dec_seg;
    logic                   wr_in_range;
    logic                   wr_fire;

    seg7_hex_decode u_dec (
        .nib_i (nib_q[digit_idx_q]),
        .dp_i  (dp_q[digit_idx_q]),
        .seg_o (dec_seg)
    );

    // The lit digit's entry is frozen while driven so a write never tears a visible glyph
    assign wr_ready    = !(phase_q == DRIVE && wr_addr == 3'(digit_idx_q));
    assign wr_in_range = ({1'b0, wr_addr} < 4'(DIGITS));
    assign wr_fire     = wr_valid && wr_ready && wr_in_range;

    always_comb begin
        slot_cnt_d  = slot_cnt_q + CW'(1);
        digit_idx_d = digit_idx_q;
        if (slot_cnt_q == SLOT_LAST) begin
            slot_cnt_d  = '0;
            digit_idx_d = (digit_idx_q == IDX_LAST) ? '0 : digit_idx_q + IW'(1);
        end
        phase_d = (slot_cnt_d < BLANK_END) ? BLANK : DRIVE;

        seg_d = SEG_BLANK;
        en_d  = '1;
        if (phase_q == DRIVE) begin
            seg_d = dec_seg;
            if (dig_on[digit_idx_q]) begin
                en_d = ~(DIGITS'(1) << digit_idx_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt_q  <= '0;
            digit_idx_q <= '0;
            phase_q     <= BLANK;
            seg_q       <= SEG_BLANK;
            en_q        <= '1;
        end else begin
            slot_cnt_q  <= slot_cnt_d;
            digit_idx_q <= digit_idx_d;
            phase_q     <= phase_d;
            seg_q       <= seg_d;
            en_q        <= en_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nib_q <= '0;
            dp_q  <= '0;
        end else if (wr_fire) begin
            nib_q[wr_addr[IW-1:0]] <= wr_data;
            dp_q[wr_addr[IW-1:0]]  <= wr_dp;
        end
    end

    assign seg = seg_q;
    assign en  = en_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - randomized scoreboard bench for seg7_scan_ctrl (8- and 4-digit instances)
module tb_seg7_scan_ctrl;

    localparam int SD = 8;
    localparam int BC = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_valid;
    logic [2:0] wr_addr;
    logic [3:0] wr_data;
    logic       wr_dp;
    logic [7:0] dig_on;
    logic       wr_ready8, wr_ready4;
    logic [7:0] seg8, seg4, en8;
    logic [3:0] en4;

    seg7_scan_ctrl #(.DIGITS(8), .SCAN_DIV(SD), .BLANK_CYC(BC)) dut8 (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready8),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_dp(wr_dp),
        .dig_on(dig_on), .seg(seg8), .en(en8)
    );

    seg7_scan_ctrl #(.DIGITS(4), .SCAN_DIV(SD), .BLANK_CYC(BC)) dut4 (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready4),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_dp(wr_dp),
        .dig_on(dig_on[3:0]), .seg(seg4), .en(en4)
    );

    always #5 clk = ~clk;

    localparam logic [7:0] HEX [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    int         n_checks = 0;
    int         n_pass   = 0;
    int         k;
    int         nd [2] = '{8, 4};
    logic [3:0] nib_m [2][8];
    logic       dp_m  [2][8];
    bit         pending;
    logic [2:0] held_addr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, k);
    endtask

    // Scan position is pure arithmetic on the edge count since reset release
    function automatic int m_idx(int d);
        return (k / SD) % nd[d];
    endfunction

    function automatic bit m_blank();
        return (k % SD) < BC;
    endfunction

    function automatic bit m_ready(int d);
        return !(!m_blank() && int'(wr_addr) == m_idx(d));
    endfunction

    function automatic logic [7:0] m_seg(int d);
        int i = m_idx(d);
        if (m_blank()) return 8'hFF;
        return HEX[nib_m[d][i]] & (dp_m[d][i] ? 8'h7F : 8'hFF);
    endfunction

    function automatic logic [7:0] m_en(int d);
        logic [7:0] all = 8'((1 << nd[d]) - 1);
        int i = m_idx(d);
        if (m_blank() || !dig_on[i]) return all;
        return all & ~(8'(1) << i);
    endfunction

    task automatic model_reset();
        k = 0;
        pending = 0;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 8; i++) begin
                nib_m[d][i] = 4'h0;
                dp_m[d][i]  = 1'b0;
            end
    endtask

    // mode 0: idle, 1: random writes and dig_on, 2: hold a write to the lit digit
    task automatic step(input int mode);
        logic [7:0] es [2];
        logic [7:0] ee [2];
        bit         acc [2];
        @(negedge clk);
        wr_data = 4'($urandom);
        wr_dp   = 1'($urandom);
        case (mode)
            0: begin
                wr_valid = 1'b0;
                wr_addr  = 3'($urandom);
            end
            1: begin
                wr_valid = ($urandom_range(0, 3) != 0);
                wr_addr  = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 15) == 0)
                    dig_on = ($urandom_range(0, 1) == 1) ? 8'hFB : 8'($urandom);
            end
            default: begin
                if (!pending) begin
                    held_addr = 3'(m_idx(0));
                    pending   = 1;
                end
                wr_valid = 1'b1;
                wr_addr  = held_addr;
            end
        endcase
        #1;
        check("wr_ready8", 32'(wr_ready8), 32'(m_ready(0)));
        check("wr_ready4", 32'(wr_ready4), 32'(m_ready(1)));
        for (int d = 0; d < 2; d++) begin
            es[d]  = m_seg(d);
            ee[d]  = m_en(d);
            acc[d] = wr_valid && m_ready(d);
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++)
            if (acc[d] && int'(wr_addr) < nd[d]) begin
                nib_m[d][wr_addr] = wr_data;
                dp_m[d][wr_addr]  = wr_dp;
            end
        if (acc[0]) pending = 0;
        k++;
        #1;
        check("seg8", 32'(seg8), 32'(es[0]));
        check("en8",  32'(en8),  32'(ee[0]));
        check("seg4", 32'(seg4), 32'(es[1]));
        check("en4",  32'(en4),  32'(ee[1][3:0]));
    endtask

    initial begin
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        wr_addr  = 3'd0;
        wr_data  = 4'd0;
        wr_dp    = 1'b0;
        dig_on   = 8'hFF;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_seg8", 32'(seg8), 32'hFF);
        check("rst_en8",  32'(en8),  32'hFF);
        check("rst_en4",  32'(en4),  32'hF);
        rst_n = 1'b1;

        repeat (70) step(0);
        repeat (800) step(1);
        dig_on = 8'hFF;
        repeat (200) step(2);
        dig_on = 8'hFB;
        repeat (80) step(1);

        dig_on = 8'hFF;
        while ((k % 64) != 46) step(0);
        check("pre_rst_en8", 32'(en8), 32'hDF);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_seg8", 32'(seg8), 32'hFF);
        check("async_en8",  32'(en8),  32'hFF);
        check("async_seg4", 32'(seg4), 32'hFF);
        check("async_en4",  32'(en4),  32'hF);
        @(posedge clk);
        #1;
        check("held_seg8", 32'(seg8), 32'hFF);
        rst_n = 1'b1;
        model_reset();
        repeat (20) step(0);
        repeat (200) step(1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
